// File: rtl/approx_mult_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : approx_mult_sweep_ctrl
// Description : Self-test sequencer for a W-bit approximate multiplier. It
//               drives every operand pair (2^(2W) of them) into the multiplier,
//               compares each result with the exact product and accumulates
//               the error statistics for software to read back.
//
// Ports
//   clk          in   1     clock, rising edge
//   rst_n        in   1     asynchronous active-low reset
//   start        in   1     begin a sweep (accepted only in IDLE or DONE)
//   busy         out  1     sweep in progress
//   done         out  1     results valid, held until the next accepted start
//   mult_a       out  W     operand A to the multiplier (idx upper half)
//   mult_b       out  W     operand B to the multiplier (idx lower half)
//   mult_c       in   2W    multiplier result
//   err_count    out  2W+1  number of pairs with approx != exact
//   abs_err_sum  out  4W    sum of |approx - exact|
//   max_abs_err  out  2W    maximum |approx - exact|
//   rel_err_sum  out  6W    sum of (|diff| << 2W) / exact, Q(4W).(2W)
//                           (only with APPROX_SWEEP_MRED_EN)
//
// Configuration macro
//   APPROX_SWEEP_MRED_EN : adds a restoring serial divider, the DIV state and
//                          the rel_err_sum port.
//
// Revision    : 1.0  initial release
// ============================================================================
module approx_mult_sweep_ctrl #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [W-1:0]       mult_a,
    output logic [W-1:0]       mult_b,
    input  logic [2*W-1:0]     mult_c,
    output logic [2*W:0]       err_count,
    output logic [4*W-1:0]     abs_err_sum,
    output logic [2*W-1:0]     max_abs_err
`ifdef APPROX_SWEEP_MRED_EN
    ,
    output logic [6*W-1:0]     rel_err_sum
`endif
);

    localparam int c_PW  = 2 * W;
    localparam int c_SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_SCW-1:0] c_SETTLE_LAST = c_SCW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_CAPTURE = 3'd2,
        S_ACCUM   = 3'd3,
        S_DONE    = 3'd4
`ifdef APPROX_SWEEP_MRED_EN
        ,
        S_DIV     = 3'd5
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [c_PW-1:0]    r_idx;
    logic [c_SCW-1:0]   r_settle_cnt;
    logic [c_PW-1:0]    r_diff;

    logic [c_PW-1:0]    w_exact;
    logic [c_PW-1:0]    w_diff;
    logic [c_PW-1:0]    w_idx_inc;
    logic               w_accept;
    logic               w_idx_last;

    assign w_exact    = c_PW'(mult_a) * c_PW'(mult_b);
    // Unsigned magnitude of the error; never wraps.
    assign w_diff     = (mult_c >= w_exact) ? (mult_c - w_exact) : (w_exact - mult_c);
    assign w_idx_inc  = r_idx + c_PW'(1);
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_idx_last = &r_idx;

`ifdef APPROX_SWEEP_MRED_EN
    localparam int c_QW  = 4 * W;
    localparam int c_DCW = $clog2(c_QW);
    localparam logic [c_DCW-1:0] c_DIV_LAST = c_DCW'(c_QW - 1);

    // Restoring divider: r_dq starts as the dividend (diff << 2W) and, as its
    // bits are shifted into the remainder, quotient bits are shifted in from
    // the bottom. After 4W steps r_dq holds the full quotient.
    logic [c_PW-1:0]    r_exact;
    logic [c_PW-1:0]    r_rem;
    logic [c_QW-1:0]    r_dq;
    logic [c_DCW-1:0]   r_div_cnt;

    logic [c_PW:0]      w_trial;
    logic [c_PW:0]      w_sub;
    logic               w_ge;

    assign w_trial = {r_rem, r_dq[c_QW-1]};
    assign w_ge    = (w_trial >= {1'b0, r_exact});
    assign w_sub   = w_trial - {1'b0, r_exact};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
`ifdef APPROX_SWEEP_MRED_EN
                // Exact product of zero has no defined relative error.
                w_state_next = (w_exact != '0) ? S_DIV : S_ACCUM;
`else
                w_state_next = S_ACCUM;
`endif
            end
`ifdef APPROX_SWEEP_MRED_EN
            S_DIV: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_state_next = S_ACCUM;
                end
            end
`endif
            S_ACCUM: begin
                w_state_next = w_idx_last ? S_DONE : S_APPLY;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: index, operands, capture and accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_settle_cnt <= '0;
            r_diff       <= '0;
            mult_a       <= '0;
            mult_b       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_count    <= '0;
            abs_err_sum  <= '0;
            max_abs_err  <= '0;
`ifdef APPROX_SWEEP_MRED_EN
            r_exact      <= '0;
            r_rem        <= '0;
            r_dq         <= '0;
            r_div_cnt    <= '0;
            rel_err_sum  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_idx        <= '0;
                        r_settle_cnt <= '0;
                        mult_a       <= '0;
                        mult_b       <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err_count    <= '0;
                        abs_err_sum  <= '0;
                        max_abs_err  <= '0;
`ifdef APPROX_SWEEP_MRED_EN
                        rel_err_sum  <= '0;
`endif
                    end
                end
                S_APPLY: begin
                    if (r_settle_cnt != c_SETTLE_LAST) begin
                        r_settle_cnt <= r_settle_cnt + c_SCW'(1);
                    end
                end
                S_CAPTURE: begin
                    r_diff <= w_diff;
`ifdef APPROX_SWEEP_MRED_EN
                    r_exact   <= w_exact;
                    r_rem     <= '0;
                    r_dq      <= {w_diff, {c_PW{1'b0}}};
                    r_div_cnt <= '0;
`endif
                end
`ifdef APPROX_SWEEP_MRED_EN
                S_DIV: begin
                    r_rem     <= w_ge ? w_sub[c_PW-1:0] : w_trial[c_PW-1:0];
                    r_dq      <= {r_dq[c_QW-2:0], w_ge};
                    r_div_cnt <= r_div_cnt + c_DCW'(1);
                end
`endif
                S_ACCUM: begin
                    if (r_diff != '0) begin
                        err_count   <= err_count + (c_PW + 1)'(1);
                        abs_err_sum <= abs_err_sum + (4 * W)'(r_diff);
                        if (r_diff > max_abs_err) begin
                            max_abs_err <= r_diff;
                        end
                    end
`ifdef APPROX_SWEEP_MRED_EN
                    // r_dq only holds a quotient when the DIV state ran.
                    if (r_exact != '0) begin
                        rel_err_sum <= rel_err_sum + (6 * W)'(r_dq);
                    end
`endif
                    if (w_idx_last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        r_idx        <= w_idx_inc;
                        mult_a       <= w_idx_inc[c_PW-1:W];
                        mult_b       <= w_idx_inc[W-1:0];
                        r_settle_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
